// File: rtl/cmp_pkg.sv
// Shared comparator result codes and sequencer state encoding.
package cmp_pkg;

  // Active-low result codes: the cleared bit marks the relation that holds.
  localparam logic [2:0] CMP_EQ = 3'b101;
  localparam logic [2:0] CMP_GT = 3'b011;
  localparam logic [2:0] CMP_LT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nib_cmp.sv
// Combinational unsigned magnitude comparator producing an active-low relation code.
module nib_cmp
  import cmp_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2:0]   code
);

  always_comb begin
    code = CMP_EQ;
    if (a > b)      code = CMP_GT;
    else if (a < b) code = CMP_LT;
  end

endmodule

// File: rtl/sort4_ctrl.sv
// In-place bubble sort of N entries using one shared comparator, one compare-and-swap per clock.
module sort4_ctrl
  import cmp_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int SW = $clog2(N*(N-1)/2+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           order,
  input  logic [N*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] dout,
  output logic [SW-1:0]  swaps
);

  localparam int IW = $clog2(N);

  state_t        state, state_nxt;
  logic [W-1:0]  ents [N];
  logic          ord_q;
  logic          pflag;
  logic [IW-1:0] i, lim, ip1;
  logic [W-1:0]  opa, opb;
  logic [2:0]    code;
  logic          swap_en;
  logic          pass_end;

  assign ip1 = i + IW'(1);
  assign opa = ents[i];
  assign opb = ents[ip1];

  nib_cmp #(.W(W)) u_cmp (
    .a    (opa),
    .b    (opb),
    .code (code)
  );

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign dout[W*g +: W] = ents[g];
  end

  assign busy = (state == ST_CMP);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    swap_en   = 1'b0;
    pass_end  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CMP;
      ST_CMP: begin
        swap_en  = ((code == CMP_GT) && !ord_q) || ((code == CMP_LT) && ord_q);
        pass_end = (i == lim);
        // Early exit once a whole pass, this compare included, left the data untouched.
        if (pass_end && ((lim == '0) || !(pflag || swap_en))) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) ents[k] <= '0;
      ord_q <= 1'b0;
      swaps <= '0;
      pflag <= 1'b0;
      i     <= '0;
      lim   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          for (int k = 0; k < N; k++) ents[k] <= din[W*k +: W];
          ord_q <= order;
          swaps <= '0;
          pflag <= 1'b0;
          i     <= '0;
          lim   <= IW'(N-2);
        end
        ST_CMP: begin
          if (swap_en) begin
            ents[i]   <= opb;
            ents[ip1] <= opa;
            swaps     <= swaps + SW'(1);
            pflag     <= 1'b1;
          end
          if (!pass_end) begin
            i <= ip1;
          end else if (state_nxt == ST_CMP) begin
            // Next pass: the largest remaining element is already in place.
            lim   <= lim - IW'(1);
            i     <= '0;
            pflag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: directed cases plus randomized sorts against a reference model.
module tb_sort4_ctrl;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = $clog2(N*(N-1)/2+1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           order;
  logic [N*W-1:0] din;
  logic           busy;
  logic           done;
  logic [N*W-1:0] dout;
  logic [SW-1:0]  swaps;

  int n_chk = 0;
  int n_err = 0;

  sort4_ctrl #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .order (order),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .swaps (swaps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected sorted vector, swap count (inversions) and compare count (pass-by-pass rule).
  function automatic void model(input logic [N*W-1:0] vin, input logic ord,
                                output logic [N*W-1:0] vout, output int nsw, output int ncmp);
    int a[N];
    int s[N];
    int t;
    bit sw;
    for (int k = 0; k < N; k++) begin
      a[k] = int'(vin[W*k +: W]);
      s[k] = a[k];
    end
    nsw = 0;
    for (int j = 0; j < N; j++)
      for (int k = j + 1; k < N; k++)
        if (ord ? (a[j] < a[k]) : (a[j] > a[k])) nsw++;
    for (int j = 1; j < N; j++) begin
      t = s[j];
      for (int k = j - 1; k >= 0; k--) begin
        if (ord ? (s[k] < t) : (s[k] > t)) begin
          s[k+1] = s[k];
          s[k]   = t;
        end else break;
      end
    end
    vout = '0;
    for (int k = 0; k < N; k++) vout[W*k +: W] = W'(s[k]);
    ncmp = 0;
    for (int lim = N - 2; lim >= 0; lim--) begin
      sw = 1'b0;
      for (int j = 0; j <= lim; j++) begin
        ncmp++;
        if (ord ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
  endfunction

  task automatic run_sort(input string tag, input logic [N*W-1:0] vin, input logic ord, input bit inject);
    logic [N*W-1:0] exp_d;
    int exp_sw, exp_cmp, cyc, nbusy;
    bit seen;
    model(vin, ord, exp_d, exp_sw, exp_cmp);
    @(negedge clk);
    din = vin; order = ord; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = (N*W)'($urandom);
    order = ~ord;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      start = 1'b0;
      if (inject && (cyc == 2 || done)) begin
        start = 1'b1;
        din   = (N*W)'($urandom);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cmp + 1));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_cmp));
    check({tag, "_dout"}, 32'(dout), 32'(exp_d));
    check({tag, "_swaps"}, 32'(swaps), 32'(exp_sw));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
    check({tag, "_dout_hold"}, 32'(dout), 32'(exp_d));
  endtask

  initial begin
    logic [N*W-1:0] v;
    bit seen;
    rst = 1'b1; start = 1'b0; order = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_swaps", 32'(swaps), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_stays", 32'({busy, done}), 32'd0);

    run_sort("asc", {4'd0, 4'd2, 4'd1, 4'd3}, 1'b0, 1'b0);
    check("asc_tp", 32'({swaps, dout}), 32'({3'd5, 4'd3, 4'd2, 4'd1, 4'd0}));
    run_sort("early", {4'd3, 4'd2, 4'd1, 4'd0}, 1'b0, 1'b0);
    check("early_tp", 32'({swaps, dout}), 32'({3'd0, 4'd3, 4'd2, 4'd1, 4'd0}));
    run_sort("desc", {4'd3, 4'd2, 4'd1, 4'd0}, 1'b1, 1'b0);
    check("desc_tp", 32'({swaps, dout}), 32'({3'd6, 4'd0, 4'd1, 4'd2, 4'd3}));
    run_sort("equal", {4'd5, 4'd5, 4'd5, 4'd5}, 1'b0, 1'b0);
    run_sort("busy_start", {4'd9, 4'd15, 4'd4, 4'd7}, 1'b0, 1'b1);
    run_sort("after_done", {4'd1, 4'd8, 4'd6, 4'd2}, 1'b1, 1'b0);

    // Reset in cycle k+3 of a worst-case sort.
    @(negedge clk);
    din = {4'd0, 4'd2, 4'd1, 4'd3}; order = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_dout", 32'(dout), 32'd0);
    check("rstmid_swaps", 32'(swaps), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rstmid_no_done", 32'(seen), 32'd0);

    for (int r = 0; r < 40; r++) begin
      v = (N*W)'($urandom);
      if (r % 5 == 0) v[W +: W] = v[0 +: W];
      run_sort("rand", v, 1'(($urandom >> 3) & 1), 1'(($urandom >> 7) & 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
